pixel_sampler_ss: RTL
=====================

// Module: pixel_sampler_ss
// PURPOSE
// Supersampling successor to the single-sample pixel sampler. Accepts integer pixel coords,
// expands each into SAMPLES sub-pixel positions (stratified grid or LFSR jitter) and emits
// signed fixed-point normalized screen coords in [-1,1) to the ray generator, valid/ready both sides.
// PARAMETERS
// PIXEL_W  800     horizontal resolution
// PIXEL_H  600     vertical resolution
// XW/YW    10/10   pixel_x / pixel_y widths
// OUT_W    17      output width, signed Q2.(OUT_W-2); FRAC=OUT_W-2, ONE=2**FRAC
// GRID     2       samples per axis, power of 2, 1..8; SAMPLES=GRID*GRID
// MODE     GRID_M  GRID_M (stratified cell centres) or JITTER_M (LFSR offsets)
// SEED     16'hACE1  LFSR reset/reseed value, nonzero
// PORTS
// clk          in   1      clock
// rst_n        in   1      async active-low reset
// in_valid     in   1      pixel coords valid
// in_ready     out  1      pixel accepted when in_valid&in_ready
// pixel_x      in   XW     pixel column
// pixel_y      in   YW     pixel row (0 = top)
// reseed       in   1      reload LFSR with SEED (frame start)
// out_valid    out  1      sample valid
// out_ready    in   1      downstream accepts sample
// normalized_x out  OUT_W  signed x, -1 left edge
// normalized_y out  OUT_W  signed y, +1 top edge
// sample_idx   out  max(1,$clog2(SAMPLES))  sample number within pixel
// out_last     out  1      last sample of pixel
// BEHAVIOUR
// - Reset: in_ready=0 during reset, 1 first cycle after; out_valid=0, outputs 0, FSM IDLE, LFSR=SEED.
// - FSM IDLE: in_ready=1; accept latches px,py, idx=0 -> EMIT. EMIT: one sample/cycle into pipe when
//   pipe enabled; idx==SAMPLES-1 issued -> IDLE, and in_ready=1 that same cycle (back-to-back, no bubble).
// - Pipe enable en = out_ready | ~out_valid; all 3 stages and the generator freeze when en=0.
// - Offsets in 1/16 pixel (OFF_BITS=4). GRID_M: ix=idx%GRID, iy=idx/GRID, o=(2*i+1)*16/(2*GRID).
//   JITTER_M: ox=lfsr[3:0], oy=lfsr[7:4]; 16-bit Galois LFSR taps 16,14,13,11 steps once per issued sample.
// - reseed loads SEED; reseed and step in same cycle -> reseed wins. Does not disturb pipe/FSM.
// - Stage1: ux=px*16+ox, uy=py*16+oy. Stage2: mx=ux*RECIP_W, my=uy*RECIP_H, RECIP=round(2**24/dim).
// - Stage3: SH=4+24-FRAC-1; nx=(mx>>SH)-ONE; ny=ONE-(my>>SH); truncating shifts, full-width intermediates.
// - Latency: accept at edge N -> first sample out_valid after edge N+3; then 1 sample/cycle if out_ready.
// - sample_idx/out_last travel with data. No clamping: out-of-range pixel computes arithmetically.
// - Output held stable while out_valid & ~out_ready. Reset mid-pixel drops remaining samples.
// STRUCTURE
// - Package sampler_pkg: mode enum {GRID_M,JITTER_M}, OFF_BITS=4, RECIP_SH=24, function recip(dim).
// - Sub-module sample_offset_gen: idx counter, grid/LFSR offsets, reseed, last flag; top holds FSM+pipe.
// TESTING
// - Reset: hold rst_n=0 4 cycles -> out_valid=0, in_ready=0; release -> in_ready=1 next cycle.
// - GRID=1, (400,300) -> 3 cycles later nx=41, ny=-54, out_last=1; (0,0) -> nx=-32728, ny=32714.
// - GRID=2, back-to-back pixels, out_ready=1 -> 4 samples each, idx 0..3, no bubble, last on idx 3.
// - out_ready=0 for 5 cycles mid-pixel -> data/idx held, in_ready=0, no sample lost or duplicated.
// - JITTER_M: reseed then pixel twice -> identical offset sequence; reseed+step same cycle -> SEED.
// - Assert rst_n mid-EMIT -> out_valid=0 immediately, FSM IDLE, LFSR=SEED, next pixel starts idx 0.

Source files
------------

// File: rtl/pixel_sampler_ss_pkg.sv
`default_nettype none
// ============================================================================
// sampler_pkg : shared types and constants for the supersampling pixel sampler
// Rev 1.0
// ============================================================================
package sampler_pkg;

  typedef enum logic [0:0] {GRID_M = 1'b0, JITTER_M = 1'b1} mode_e;
  typedef enum logic [0:0] {IDLE = 1'b0, EMIT = 1'b1} state_e;

  localparam int OFF_BITS = 4;
  localparam int RECIP_SH = 24;

  // Rounded 2**RECIP_SH / dim; one extra bit so dim=1 still fits.
  function automatic logic [RECIP_SH:0] recip(input int dim);
    longint r;
    r = ((longint'(1) << RECIP_SH) + longint'(dim / 2)) / longint'(dim);
    return r[RECIP_SH:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/pixel_sampler_ss_if.sv
`default_nettype none
// ============================================================================
// pixel_sampler_ss_if : pixel-in / sample-out valid-ready streams
// Rev 1.0
// ============================================================================
interface pixel_sampler_ss_if #(
  parameter int XW    = 10,
  parameter int YW    = 10,
  parameter int OUT_W = 17,
  parameter int IDX_W = 2
);
  logic                    in_valid;
  logic                    in_ready;
  logic [XW-1:0]           pixel_x;
  logic [YW-1:0]           pixel_y;
  logic                    reseed;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [OUT_W-1:0] normalized_x;
  logic signed [OUT_W-1:0] normalized_y;
  logic [IDX_W-1:0]        sample_idx;
  logic                    out_last;

  modport master (
    output in_valid, pixel_x, pixel_y, reseed, out_ready,
    input  in_ready, out_valid, normalized_x, normalized_y, sample_idx, out_last
  );

  modport slave (
    input  in_valid, pixel_x, pixel_y, reseed, out_ready,
    output in_ready, out_valid, normalized_x, normalized_y, sample_idx, out_last
  );
endinterface
`default_nettype wire

// File: rtl/pixel_sampler_ss_offset_gen.sv
`default_nettype none
// ============================================================================
// sample_offset_gen : sample index counter and sub-pixel offset source
// Rev 1.0
// ============================================================================
module sample_offset_gen
  import sampler_pkg::*;
#(
  parameter int          GRID  = 2,
  parameter mode_e       MODE  = GRID_M,
  parameter logic [15:0] SEED  = 16'hACE1,
  parameter int          IDX_W = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                issue,
  input  logic                reseed,
  output logic [IDX_W-1:0]    idx,
  output logic                last,
  output logic [OFF_BITS-1:0] ox,
  output logic [OFF_BITS-1:0] oy
);
  localparam int SAMPLES = GRID * GRID;

  logic [IDX_W-1:0] idx_q, idx_d;
  logic [15:0]      lfsr_q, lfsr_d;

  always_comb begin
    idx_d = idx_q;
    if (start) begin
      idx_d = '0;
    end else if (issue) begin
      idx_d = idx_q + IDX_W'(1);
    end
    // Galois form, taps 16,14,13,11; a reseed overrides a same-cycle step
    lfsr_d = lfsr_q;
    if (reseed) begin
      lfsr_d = SEED;
    end else if (issue) begin
      lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q  <= '0;
      lfsr_q <= SEED;
    end else begin
      idx_q  <= idx_d;
      lfsr_q <= lfsr_d;
    end
  end

  assign idx  = idx_q;
  assign last = (idx_q == IDX_W'(SAMPLES - 1));

  generate
    if (MODE == JITTER_M) begin : g_jitter
      assign ox = lfsr_q[OFF_BITS-1:0];
      assign oy = lfsr_q[2*OFF_BITS-1:OFF_BITS];
    end else begin : g_grid
      assign ox = OFF_BITS'((2 * (int'(idx_q) % GRID) + 1) * (1 << OFF_BITS) / (2 * GRID));
      assign oy = OFF_BITS'((2 * (int'(idx_q) / GRID) + 1) * (1 << OFF_BITS) / (2 * GRID));
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/pixel_sampler_ss.sv
`default_nettype none
// ============================================================================
// pixel_sampler_ss : expands each pixel into GRID*GRID sub-pixel samples and
// emits signed Q2.(OUT_W-2) normalised screen coordinates.   Rev 1.0
// ============================================================================
module pixel_sampler_ss
  import sampler_pkg::*;
#(
  parameter int          PIXEL_W = 800,
  parameter int          PIXEL_H = 600,
  parameter int          XW      = 10,
  parameter int          YW      = 10,
  parameter int          OUT_W   = 17,
  parameter int          GRID    = 2,
  parameter mode_e       MODE    = GRID_M,
  parameter logic [15:0] SEED    = 16'hACE1
) (
  input logic               clk,
  input logic               rst_n,
  pixel_sampler_ss_if.slave bus
);
  localparam int SAMPLES = GRID * GRID;
  localparam int IDX_W   = (SAMPLES > 1) ? $clog2(SAMPLES) : 1;
  localparam int FRAC    = OUT_W - 2;
  localparam int SH      = OFF_BITS + RECIP_SH - FRAC - 1;
  localparam int UX_W    = XW + OFF_BITS;
  localparam int UY_W    = YW + OFF_BITS;
  localparam int MX_W    = UX_W + RECIP_SH + 1;
  localparam int MY_W    = UY_W + RECIP_SH + 1;
  localparam logic [RECIP_SH:0] RECIP_X = recip(PIXEL_W);
  localparam logic [RECIP_SH:0] RECIP_Y = recip(PIXEL_H);
  localparam logic [OUT_W-1:0]  ONE     = OUT_W'(1) << FRAC;

  state_e           state_q, state_d;
  logic             alive_q, alive_d;
  logic [XW-1:0]    px_q, px_d;
  logic [YW-1:0]    py_q, py_d;
  logic             v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
  logic             l1_q, l1_d, l2_q, l2_d, l3_q, l3_d;
  logic [IDX_W-1:0] i1_q, i1_d, i2_q, i2_d, i3_q, i3_d;
  logic [UX_W-1:0]  ux_q, ux_d;
  logic [UY_W-1:0]  uy_q, uy_d;
  logic [MX_W-1:0]  mx_q, mx_d;
  logic [MY_W-1:0]  my_q, my_d;
  logic [OUT_W-1:0] nx_q, nx_d, ny_q, ny_d;

  logic                en, issue, accept, in_ready, gen_last;
  logic [IDX_W-1:0]    gen_idx;
  logic [OFF_BITS-1:0] ox, oy;

  assign en       = bus.out_ready | ~v3_q;
  assign issue    = (state_q == EMIT) & en;
  // Ready again in the cycle the last sample issues so pixels stream without a bubble
  assign in_ready = alive_q & ((state_q == IDLE) | (issue & gen_last));
  assign accept   = bus.in_valid & in_ready;

  sample_offset_gen #(
    .GRID  (GRID),
    .MODE  (MODE),
    .SEED  (SEED),
    .IDX_W (IDX_W)
  ) u_offset_gen (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (accept),
    .issue  (issue),
    .reseed (bus.reseed),
    .idx    (gen_idx),
    .last   (gen_last),
    .ox     (ox),
    .oy     (oy)
  );

  always_comb begin
    alive_d = 1'b1;
    state_d = state_q;
    px_d    = px_q;
    py_d    = py_q;
    if (accept) begin
      px_d = bus.pixel_x;
      py_d = bus.pixel_y;
    end
    if (state_q == IDLE) begin
      if (accept) state_d = EMIT;
    end else if (issue && gen_last) begin
      state_d = accept ? EMIT : IDLE;
    end

    v1_d = v1_q; ux_d = ux_q; uy_d = uy_q; i1_d = i1_q; l1_d = l1_q;
    v2_d = v2_q; mx_d = mx_q; my_d = my_q; i2_d = i2_q; l2_d = l2_q;
    v3_d = v3_q; nx_d = nx_q; ny_d = ny_q; i3_d = i3_q; l3_d = l3_q;
    if (en) begin
      // Offsets are below 16, so concatenation equals px*16+ox
      v1_d = issue;
      ux_d = {px_q, ox};
      uy_d = {py_q, oy};
      i1_d = gen_idx;
      l1_d = gen_last;
      v2_d = v1_q;
      mx_d = MX_W'(ux_q) * MX_W'(RECIP_X);
      my_d = MY_W'(uy_q) * MY_W'(RECIP_Y);
      i2_d = i1_q;
      l2_d = l1_q;
      v3_d = v2_q;
      nx_d = OUT_W'(mx_q >> SH) - ONE;
      ny_d = ONE - OUT_W'(my_q >> SH);
      i3_d = i2_q;
      l3_d = l2_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      alive_q <= 1'b0;
      px_q <= '0; py_q <= '0;
      v1_q <= 1'b0; ux_q <= '0; uy_q <= '0; i1_q <= '0; l1_q <= 1'b0;
      v2_q <= 1'b0; mx_q <= '0; my_q <= '0; i2_q <= '0; l2_q <= 1'b0;
      v3_q <= 1'b0; nx_q <= '0; ny_q <= '0; i3_q <= '0; l3_q <= 1'b0;
    end else begin
      state_q <= state_d;
      alive_q <= alive_d;
      px_q <= px_d; py_q <= py_d;
      v1_q <= v1_d; ux_q <= ux_d; uy_q <= uy_d; i1_q <= i1_d; l1_q <= l1_d;
      v2_q <= v2_d; mx_q <= mx_d; my_q <= my_d; i2_q <= i2_d; l2_q <= l2_d;
      v3_q <= v3_d; nx_q <= nx_d; ny_q <= ny_d; i3_q <= i3_d; l3_q <= l3_d;
    end
  end

  assign bus.in_ready     = in_ready;
  assign bus.out_valid    = v3_q;
  assign bus.normalized_x = nx_q;
  assign bus.normalized_y = ny_q;
  assign bus.sample_idx   = i3_q;
  assign bus.out_last     = l3_q;

endmodule
`default_nettype wire
